// File: rtl/uart_rx_buffered.sv
// 8N1 UART receiver with 16x oversampling, framing/break/overrun flags and a 2-entry output FIFO.
// Optional build macro: UART_RX_MAJORITY_EN selects 2-of-3 majority sampling at ticks 7/8/9.
module uart_rx_buffered #(
  parameter int CLOCKFRQ = 240000000,
  parameter int BAUDRATE = 3500000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] rx_byte,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_err,
  output logic       overrun,
  output logic       break_det,
  output logic       is_receiving
);

  localparam int TICK_DIV = CLOCKFRQ / (BAUDRATE * 16);
  localparam int DIV_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_IDLE} state_t;

  state_t           state_q, state_d;
  logic             rx_meta_p0, rxs, rxs_p1;
  logic             start_edge;
  logic [DIV_W-1:0] div_cnt;
  logic             tick;
  logic [3:0]       tick_cnt;
  logic             decide, bit_val;
  logic [2:0]       bit_cnt;
  logic [7:0]       shift_q;
  logic             shift_en, push, fe_set, brk_set;
  logic             frame_err_q, overrun_q, break_q;
  logic [7:0]       mem_q [2];
  logic             wr_ptr, rd_ptr;
  logic [1:0]       count;
  logic             full, pop, wr_en;

  // stage: two-flop synchroniser plus one delayed copy for edge detection
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta_p0 <= 1'b1;
      rxs        <= 1'b1;
      rxs_p1     <= 1'b1;
    end else begin
      rx_meta_p0 <= rx;
      rxs        <= rx_meta_p0;
      rxs_p1     <= rxs;
    end
  end

  assign start_edge = rxs_p1 & ~rxs;

  // stage: oversample tick generator, phase-aligned to the start edge
  assign tick = (div_cnt == DIV_LAST);

  always_ff @(posedge clk) begin
    if (rst || (state_q == IDLE && start_edge)) begin
      div_cnt  <= '0;
      tick_cnt <= '0;
    end else begin
      div_cnt <= tick ? '0 : div_cnt + 1'b1;
      if (tick) tick_cnt <= tick_cnt + 4'd1;
    end
  end

`ifdef UART_RX_MAJORITY_EN
  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  logic smp7, smp8;

  // tick_cnt holds N-1 on the tick that is tick N of the bit
  always_ff @(posedge clk) begin
    if (tick && tick_cnt == 4'd6) smp7 <= rxs;
    if (tick && tick_cnt == 4'd7) smp8 <= rxs;
  end

  assign decide  = tick && (tick_cnt == 4'd8);
  assign bit_val = maj3(smp7, smp8, rxs);
`else
  assign decide  = tick && (tick_cnt == 4'd7);
  assign bit_val = rxs;
`endif

  // stage: receive FSM
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    shift_en = 1'b0;
    push     = 1'b0;
    fe_set   = 1'b0;
    brk_set  = 1'b0;
    case (state_q)
      IDLE:      if (start_edge) state_d = START;
      START:     if (decide) state_d = bit_val ? IDLE : DATA;
      DATA: begin
        if (decide) begin
          shift_en = 1'b1;
          if (bit_cnt == 3'd7) state_d = STOP;
        end
      end
      STOP: begin
        if (decide) begin
          if (bit_val) begin
            push    = 1'b1;
            state_d = IDLE;
          end else begin
            fe_set  = 1'b1;
            brk_set = (shift_q == 8'h00);
            state_d = WAIT_IDLE;
          end
        end
      end
      WAIT_IDLE: if (rxs) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || state_q != DATA) bit_cnt <= '0;
    else if (shift_en)          bit_cnt <= bit_cnt + 3'd1;
  end

  always_ff @(posedge clk) begin
    if (shift_en) shift_q <= {bit_val, shift_q[7:1]};
  end

  // stage: status flags and output FIFO
  assign full  = (count == 2'd2);
  assign pop   = rx_valid & rx_ready;
  assign wr_en = push & (~full | pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
      break_q     <= 1'b0;
      wr_ptr      <= 1'b0;
      rd_ptr      <= 1'b0;
      count       <= 2'd0;
    end else begin
      frame_err_q <= fe_set;
      overrun_q   <= push & full & ~pop;
      if (brk_set)  break_q <= 1'b1;
      else if (rxs) break_q <= 1'b0;
      if (wr_en) wr_ptr <= ~wr_ptr;
      if (pop)   rd_ptr <= ~rd_ptr;
      count <= count + 2'(wr_en) - 2'(pop);
    end
  end

  // a full-buffer push with a simultaneous pop lands in the slot being vacated
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr] <= shift_q;
  end

  assign rx_valid     = (count != 2'd0) & ~rst;
  assign rx_byte      = rx_valid ? mem_q[rd_ptr] : 8'h00;
  assign frame_err    = frame_err_q & ~rst;
  assign overrun      = overrun_q & ~rst;
  assign break_det    = break_q & ~rst;
  assign is_receiving = (state_q != IDLE) & ~rst;

endmodule
